rf_wb_queue: RTL and testbench

Write-back queue that owns the write port of the 8×16-bit register file (the rf_bypass instance). Accepts register-write requests from the execute/memory stages through a valid/ready handshake, buffers them in order, and drains one per cycle onto the `write`/`writeregsel`/`writedata` port unless held. Exports a per-register pending mask so decode can stall on registers with a queued write.

---
 rtl/rf_wb_pkg.sv | 15 +
 rtl/rf_wb_fifo.sv | 62 ++++++
 rtl/rf_wb_queue.sv | 95 +++++++++
 tb/tb_rf_wb_queue.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/rf_wb_pkg.sv
// Shared widths and the queued-entry layout for the register-file write-back queue.
package rf_wb_pkg;

    localparam int REG_W    = 3;
    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 8;

    typedef struct packed {
        logic [REG_W-1:0]  regsel;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    localparam int ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/rf_wb_fifo.sv
// Circular FIFO storage for write-back entries: head/tail pointers wrapping modulo DEPTH
// plus an occupancy counter. Push is suppressed by the caller when full.
module rf_wb_fifo
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  logic      pop,
    input  wb_entry_t push_entry,
    output wb_entry_t head_entry,
    output logic [CW-1:0] count
);

    wb_entry_t       mem_q [DEPTH];
    wb_entry_t       mem_d [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) begin
            mem_d[tail_q] = push_entry;
            tail_d        = tail_q + 1'b1;
        end
        if (pop) begin
            head_d = head_q + 1'b1;
        end
        // Simultaneous push and pop leaves occupancy unchanged.
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q   <= '{default: '0};
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_entry = mem_q[head_q];
    assign count      = count_q;

endmodule

// File: rtl/rf_wb_queue.sv
// Write-back queue owning the register-file write port, with a per-register pending mask.
// Optional same-cycle passthrough on an empty queue is enabled by RF_WB_PASSTHRU_EN.
module rf_wb_queue
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [REG_W-1:0]          in_reg,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      wr_hold,
    output logic                      write,
    output logic [REG_W-1:0]          writeregsel,
    output logic [DATA_W-1:0]         writedata,
    output logic [NUM_REGS-1:0]       pending,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int CW = $clog2(DEPTH) + 1;

    wb_entry_t     head_entry;
    wb_entry_t     push_entry;
    logic [CW-1:0] fifo_count;
    logic          drain;
    logic          passthru;
    logic          push;
    logic [CW-1:0] cnt_q [NUM_REGS];
    logic [CW-1:0] cnt_d [NUM_REGS];

    assign push_entry = '{regsel: in_reg, data: in_data};
    assign in_ready   = (fifo_count != CW'(DEPTH));
    assign drain      = (fifo_count != '0) && !wr_hold;

`ifdef RF_WB_PASSTHRU_EN
    // An empty, unheld queue forwards the request straight to the rf port.
    assign passthru = (fifo_count == '0) && !wr_hold && in_valid;
`else
    assign passthru = 1'b0;
`endif

    assign push = in_valid && in_ready && !passthru;

    always_comb begin
        write       = drain || passthru;
        writeregsel = head_entry.regsel;
        writedata   = head_entry.data;
        if (passthru) begin
            writeregsel = in_reg;
            writedata   = in_data;
        end
    end

    rf_wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst),
        .push       (push),
        .pop        (drain),
        .push_entry (push_entry),
        .head_entry (head_entry),
        .count      (fifo_count)
    );

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if ((push && in_reg == REG_W'(r)) && !(drain && head_entry.regsel == REG_W'(r))) begin
                cnt_d[r] = cnt_q[r] + 1'b1;
            end else if ((drain && head_entry.regsel == REG_W'(r)) && !(push && in_reg == REG_W'(r))) begin
                cnt_d[r] = cnt_q[r] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '{default: '0};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            pending[r] = (cnt_q[r] != '0);
        end
    end

    assign count = fifo_count;

endmodule

// File: tb/tb_rf_wb_queue.sv
// Bench for rf_wb_queue: directed scenarios plus random traffic against a queue-based model.
// Build with +define+RF_WB_PASSTHRU_EN to exercise the passthrough variant.
module tb_rf_wb_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_reg;
    logic [15:0] in_data;
    logic        wr_hold;
    logic        write;
    logic [2:0]  writeregsel;
    logic [15:0] writedata;
    logic [7:0]  pending;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [18:0] exp_q[$];
    logic [15:0] rf_obs [8];

    rf_wb_queue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_reg      (in_reg),
        .in_data     (in_data),
        .wr_hold     (wr_hold),
        .write       (write),
        .writeregsel (writeregsel),
        .writedata   (writedata),
        .pending     (pending),
        .count       (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check outputs, advance the model.
    task automatic step(input logic v, input logic [2:0] r, input logic [15:0] d, input logic h);
        logic        pass;
        logic        exp_write;
        logic        acc;
        logic        pop;
        logic [7:0]  exp_pend;
        logic [2:0]  exp_sel;
        logic [15:0] exp_data;
        in_valid = v;
        in_reg   = r;
        in_data  = d;
        wr_hold  = h;
        #1;
        pass = 1'b0;
`ifdef RF_WB_PASSTHRU_EN
        pass = (exp_q.size() == 0) && !h && v;
`endif
        pop       = (exp_q.size() != 0) && !h;
        exp_write = pop || pass;
        acc       = v && (exp_q.size() != DEPTH) && !pass;
        exp_pend  = '0;
        foreach (exp_q[i]) exp_pend[exp_q[i][18:16]] = 1'b1;
        check("count", 32'(count), 32'(exp_q.size()));
        check("in_ready", 32'(in_ready), 32'(exp_q.size() != DEPTH));
        check("write", 32'(write), 32'(exp_write));
        check("pending", 32'(pending), 32'(exp_pend));
        if (exp_write) begin
            exp_sel  = pass ? r : exp_q[0][18:16];
            exp_data = pass ? d : exp_q[0][15:0];
            check("writeregsel", 32'(writeregsel), 32'(exp_sel));
            check("writedata", 32'(writedata), 32'(exp_data));
        end
        if (write) rf_obs[writeregsel] = writedata;
        @(posedge clk);
        if (pop) void'(exp_q.pop_front());
        if (acc) exp_q.push_back({r, d});
        @(negedge clk);
    endtask

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_reg   = '0;
        in_data  = '0;
        wr_hold  = 1'b0;
        foreach (rf_obs[i]) rf_obs[i] = '0;
        #12;
        check("rst_count", 32'(count), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_write", 32'(write), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Single write to r3.
        step(1'b1, 3'd3, 16'hBEEF, 1'b0);
        step(1'b0, 3'd0, 16'h0000, 1'b0);
        step(1'b0, 3'd0, 16'h0000, 1'b0);
        check("rf_r3", 32'(rf_obs[3]), 32'hBEEF);

        // Backpressure: fill under hold, fifth request stalls, then drain in order.
        for (int i = 0; i < 5; i++) step(1'b1, 3'(i), 16'h1000 + 16'(i), 1'b1);
        check("full_count", 32'(count), 32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 7; i++) step(1'b0, 3'd0, 16'h0, 1'b0);

        // Same-register ordering, then push/pop at count 2 hitting r5 at both ends.
        step(1'b1, 3'd5, 16'd1, 1'b1);
        step(1'b1, 3'd5, 16'd2, 1'b1);
        step(1'b1, 3'd5, 16'd3, 1'b0);
        check("pp_count", 32'(count), 32'd2);
        check("pp_pend5", 32'(pending[5]), 32'd1);
        step(1'b0, 3'd0, 16'h0, 1'b0);
        step(1'b0, 3'd0, 16'h0, 1'b0);
        step(1'b0, 3'd0, 16'h0, 1'b0);
        check("r5_last", 32'(rf_obs[5]), 32'd3);

        // Reset mid-stream with three entries queued and the port free.
        for (int i = 0; i < 3; i++) step(1'b1, 3'(i + 2), 16'hA000 + 16'(i), 1'b1);
        in_valid = 1'b0;
        wr_hold  = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_pending", 32'(pending), 32'd0);
        check("mid_rst_write", 32'(write), 32'd0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 3'd0, 16'h0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 16'($urandom), 1'($urandom_range(0, 3) == 0));
        end
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 3'd0, 16'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
